// File: rtl/mask_centroid_tracker.sv
// Mask-pixel centroid tracker: per-frame sums, serial divide in vblank, red crosshair overlay and status LEDs.
// Optional bounding-box overlay enabled by defining MASK_CENTROID_BBOX_EN.
module mask_centroid_tracker #(
  parameter int H_BITS    = 11,
  parameter int V_BITS    = 10,
  parameter int ACC_BITS  = 32,
  parameter int CNT_BITS  = 20,
  parameter int MIN_COUNT = 64,
  parameter int ARM       = 16,
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              overlay_en,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic [H_BITS-1:0] cx,
  output logic [V_BITS-1:0] cy,
  output logic              cent_valid,
  output logic [2:0]        led
);

  localparam int unsigned BIT_W = $clog2(ACC_BITS);
  localparam logic [BIT_W-1:0]    LP_LAST  = BIT_W'(ACC_BITS - 1);
  localparam logic [H_BITS-1:0]   LP_HHALF = H_BITS'(H_ACTIVE / 2);
  localparam logic [V_BITS-1:0]   LP_VHALF = V_BITS'(V_ACTIVE / 2);
  localparam logic [H_BITS-1:0]   LP_ARMX  = H_BITS'(ARM);
  localparam logic [V_BITS-1:0]   LP_ARMY  = V_BITS'(ARM);
  localparam logic [CNT_BITS-1:0] LP_MIN   = CNT_BITS'(MIN_COUNT);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV_X, S_DIV_Y, S_UPDATE} state_t;

  logic                r_vs1, r_hs1, r_de1;
  logic [7:0]          r_r1, r_g1, r_b1;
  logic [H_BITS-1:0]   r_px1;
  logic [V_BITS-1:0]   r_py1;
  logic [H_BITS-1:0]   r_x;
  logic [V_BITS-1:0]   r_y;
  logic [CNT_BITS-1:0] r_cnt, r_sn_cnt;
  logic [ACC_BITS-1:0] r_sx, r_sy, r_sn_sx, r_sn_sy;
  logic [ACC_BITS-1:0] r_dvd;
  logic [CNT_BITS-1:0] r_rem;
  logic [BIT_W-1:0]    r_bit;
  logic [H_BITS-1:0]   r_qx;
  logic [V_BITS-1:0]   r_qy;
  state_t              r_state, w_state_nxt;

  logic                w_frame_end, w_de_fall, w_hit, w_cnt_ok, w_last;
  logic [CNT_BITS:0]   w_trial;
  logic                w_ge;
  logic [CNT_BITS-1:0] w_sub, w_rem_nxt;
  logic [ACC_BITS-1:0] w_dvd_nxt;
  logic [H_BITS-1:0]   w_dx;
  logic [V_BITS-1:0]   w_dy;
  logic                w_cross, w_box;

  assign w_frame_end = vs_in & ~r_vs1;
  assign w_de_fall   = ~de_in & r_de1;
  assign w_hit       = de_in & r_in[7];
  // A zero count is rejected even if MIN_COUNT is overridden to 0, so the divider never sees /0.
  assign w_cnt_ok    = (r_sn_cnt >= LP_MIN) && (r_sn_cnt != '0);
  assign w_last      = (r_bit == LP_LAST);

  // Stage 1: register video and the pixel position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vs1 <= 1'b0;
      r_hs1 <= 1'b0;
      r_de1 <= 1'b0;
      r_r1  <= '0;
      r_g1  <= '0;
      r_b1  <= '0;
      r_px1 <= '0;
      r_py1 <= '0;
    end else begin
      r_vs1 <= vs_in;
      r_hs1 <= hs_in;
      r_de1 <= de_in;
      r_r1  <= r_in;
      r_g1  <= g_in;
      r_b1  <= b_in;
      r_px1 <= r_x;
      r_py1 <= r_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (de_in)          r_x <= r_x + 1'b1;
      else if (w_de_fall) r_x <= '0;
      if (w_frame_end)    r_y <= '0;
      else if (w_de_fall) r_y <= r_y + 1'b1;
    end
  end

  // Accumulators restart at frame end with the current pixel already counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_sn_cnt <= '0;
      r_sn_sx  <= '0;
      r_sn_sy  <= '0;
    end else if (w_frame_end) begin
      r_sn_cnt <= r_cnt;
      r_sn_sx  <= r_sx;
      r_sn_sy  <= r_sy;
      r_cnt    <= w_hit ? CNT_BITS'(1) : '0;
      r_sx     <= w_hit ? ACC_BITS'(r_x) : '0;
      r_sy     <= w_hit ? ACC_BITS'(r_y) : '0;
    end else if (w_hit) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      r_sx <= r_sx + ACC_BITS'(r_x);
      r_sy <= r_sy + ACC_BITS'(r_y);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_IDLE;
      S_CHECK:  w_state_nxt = w_cnt_ok ? S_DIV_X : S_IDLE;
      S_DIV_X:  if (w_last) w_state_nxt = S_DIV_Y;
      S_DIV_Y:  if (w_last) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_frame_end) w_state_nxt = S_CHECK;
  end

  // Restoring divide step: remainder stays below the divisor, so CNT_BITS bits hold it.
  assign w_trial   = {r_rem, r_dvd[ACC_BITS-1]};
  assign w_ge      = w_trial >= {1'b0, r_sn_cnt};
  assign w_sub     = w_trial[CNT_BITS-1:0] - r_sn_cnt;
  assign w_rem_nxt = w_ge ? w_sub : w_trial[CNT_BITS-1:0];
  assign w_dvd_nxt = {r_dvd[ACC_BITS-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dvd      <= '0;
      r_rem      <= '0;
      r_bit      <= '0;
      r_qx       <= '0;
      r_qy       <= '0;
      cx         <= '0;
      cy         <= '0;
      cent_valid <= 1'b0;
    end else if (!w_frame_end) begin
      case (r_state)
        S_CHECK: begin
          if (w_cnt_ok) begin
            r_dvd <= r_sn_sx;
            r_rem <= '0;
            r_bit <= '0;
          end else begin
            cent_valid <= 1'b0;
          end
        end
        S_DIV_X: begin
          r_dvd <= w_dvd_nxt;
          r_rem <= w_rem_nxt;
          r_bit <= r_bit + 1'b1;
          if (w_last) begin
            r_qx  <= w_dvd_nxt[H_BITS-1:0];
            r_dvd <= r_sn_sy;
            r_rem <= '0;
            r_bit <= '0;
          end
        end
        S_DIV_Y: begin
          r_dvd <= w_dvd_nxt;
          r_rem <= w_rem_nxt;
          r_bit <= r_bit + 1'b1;
          if (w_last) r_qy <= w_dvd_nxt[V_BITS-1:0];
        end
        S_UPDATE: begin
          cx         <= r_qx;
          cy         <= r_qy;
          cent_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MASK_CENTROID_BBOX_EN
  logic [H_BITS-1:0] r_xmin, r_xmax, r_sn_xmin, r_sn_xmax, r_bx_min, r_bx_max;
  logic [V_BITS-1:0] r_ymin, r_ymax, r_sn_ymin, r_sn_ymax, r_by_min, r_by_max;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_xmin    <= '1;
      r_xmax    <= '0;
      r_ymin    <= '1;
      r_ymax    <= '0;
      r_sn_xmin <= '0;
      r_sn_xmax <= '0;
      r_sn_ymin <= '0;
      r_sn_ymax <= '0;
      r_bx_min  <= '0;
      r_bx_max  <= '0;
      r_by_min  <= '0;
      r_by_max  <= '0;
    end else begin
      if (w_frame_end) begin
        r_sn_xmin <= r_xmin;
        r_sn_xmax <= r_xmax;
        r_sn_ymin <= r_ymin;
        r_sn_ymax <= r_ymax;
        r_xmin    <= w_hit ? r_x : '1;
        r_xmax    <= w_hit ? r_x : '0;
        r_ymin    <= w_hit ? r_y : '1;
        r_ymax    <= w_hit ? r_y : '0;
      end else if (w_hit) begin
        if (r_x < r_xmin) r_xmin <= r_x;
        if (r_x > r_xmax) r_xmax <= r_x;
        if (r_y < r_ymin) r_ymin <= r_y;
        if (r_y > r_ymax) r_ymax <= r_y;
      end
      if (!w_frame_end && r_state == S_UPDATE) begin
        r_bx_min <= r_sn_xmin;
        r_bx_max <= r_sn_xmax;
        r_by_min <= r_sn_ymin;
        r_by_max <= r_sn_ymax;
      end
    end
  end

  assign w_box = overlay_en & cent_valid & r_de1 &
                 ((((r_px1 == r_bx_min) | (r_px1 == r_bx_max)) & (r_py1 >= r_by_min) & (r_py1 <= r_by_max)) |
                  (((r_py1 == r_by_min) | (r_py1 == r_by_max)) & (r_px1 >= r_bx_min) & (r_px1 <= r_bx_max)));
`else
  assign w_box = 1'b0;
`endif

  assign w_dx    = (r_px1 >= cx) ? (r_px1 - cx) : (cx - r_px1);
  assign w_dy    = (r_py1 >= cy) ? (r_py1 - cy) : (cy - r_py1);
  assign w_cross = overlay_en & cent_valid & r_de1 &
                   (((r_px1 == cx) & (w_dy <= LP_ARMY)) | ((r_py1 == cy) & (w_dx <= LP_ARMX)));

  // Stage 2: overlay, crosshair drawn over the box.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vs_out <= 1'b0;
      hs_out <= 1'b0;
      de_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      led    <= '0;
    end else begin
      vs_out <= r_vs1;
      hs_out <= r_hs1;
      de_out <= r_de1;
      if (w_cross)    {r_out, g_out, b_out} <= 24'hFF0000;
      else if (w_box) {r_out, g_out, b_out} <= 24'h00FF00;
      else            {r_out, g_out, b_out} <= {r_r1, r_g1, r_b1};
      led <= {cent_valid & (cy < LP_VHALF), cent_valid & (cx < LP_HHALF), cent_valid};
    end
  end

endmodule

// File: doc/mask_centroid_tracker.md
Name: mask_centroid_tracker

Overview:
- Sits directly downstream of the per-pixel colour-classifier stage and consumes its black/white mask video stream.
- Accumulates the pixel count and the x/y coordinate sums of mask pixels over each frame, then divides them to find the centroid during vertical blanking.
- Overlays a red crosshair at the previous frame's centroid, exports the centroid coordinates, and drives status LEDs.

Parameters:
- H_BITS, 11: x counter width (1280 active).
- V_BITS, 10: y counter width (720 active).
- ACC_BITS, 32: width of the x-sum and y-sum accumulators.
- CNT_BITS, 20: width of the pixel count accumulator.
- MIN_COUNT, 64: minimum mask pixels for a valid centroid.
- ARM, 16: crosshair half-length in pixels.
- H_ACTIVE, 1280: active width, used for the led[1] test.
- V_ACTIVE, 720: active height, used for the led[2] test.

Ports:
- clk  in  1  pixel clock, 74.25 MHz
- reset_n  in  1  synchronous active-low reset
- overlay_en  in  1  1 = draw crosshair
- vs_in  in  1  vertical sync; rising edge = new frame
- hs_in  in  1  horizontal sync
- de_in  in  1  data enable
- r_in  in  8  red; mask pixel = r_in[7]
- g_in  in  8  green, passthrough
- b_in  in  8  blue, passthrough
- vs_out  out  1  delayed vs
- hs_out  out  1  delayed hs
- de_out  out  1  delayed de
- r_out  out  8  red out
- g_out  out  8  green out
- b_out  out  8  blue out
- cx  out  H_BITS  centroid x
- cy  out  V_BITS  centroid y
- cent_valid  out  1  centroid valid
- led  out  3  status LEDs

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low, on reset_n.
- While reset_n=0 at a clk edge, all of the following are 0: outputs, counters, accumulators, cent_valid, and the FSM (which goes to IDLE).
- Video path: fixed 2-cycle latency from every *_in to the matching *_out.
  - Stage 1 registers the inputs and current (x,y).
  - Stage 2 applies the overlay.
- Position counters:
  - x increments on each de_in=1 cycle and clears on the de_in falling edge.
  - y increments on each de_in falling edge and clears on the vs_in rising edge.
  - Pixel (x,y) is the position before the increment.
- Accumulation: on de_in=1 with r_in[7]=1, add 1 to cnt, x to sx, and y to sy.
  - cnt saturates at all-ones and does not wrap.
- Frame end (vs_in rising edge, detected from the registered vs):
  - snapshot cnt/sx/sy into the divider registers;
  - clear the accumulators in the same cycle (a pixel in that cycle counts toward the new frame);
  - start the FSM.
- FSM states:
  - IDLE: on frame end, go to CHECK.
  - CHECK: if cnt < MIN_COUNT, set cent_valid=0 and go to IDLE; else go to DIV_X.
  - DIV_X: serial restoring divide sx/cnt, one quotient bit per cycle, ACC_BITS cycles, then go to DIV_Y.
  - DIV_Y: same for sy/cnt, then go to UPDATE.
  - UPDATE: load cx and cy (floored quotients, truncated to H_BITS/V_BITS), set cent_valid=1, go to IDLE.
  - Total time from frame end to update is ≤ 2*ACC_BITS+3 cycles; this completes inside vertical blanking.
- cnt=0 always takes the CHECK→IDLE path, so the divider never divides by zero.
- A frame end during DIV_X, DIV_Y or UPDATE aborts the divide, takes a new snapshot and goes to CHECK. cx, cy and cent_valid keep their previous values until the next UPDATE or a failed CHECK.
- Overlay, stage 2: when overlay_en, cent_valid and de are all 1, and either
  - x==cx and |y−cy|≤ARM, or
  - y==cy and |x−cx|≤ARM,
  
  the output pixel is FF,00,00. Otherwise the input RGB passes unchanged. The distance compares are unsigned-safe and there is no wrap at the frame edges.
- LEDs, registered:
  - led[0] = cent_valid
  - led[1] = cent_valid & (cx < H_ACTIVE/2)
  - led[2] = cent_valid & (cy < V_ACTIVE/2)

Optional Feature:
- Macro: MASK_CENTROID_BBOX_EN.
- When defined: track min/max x and y of mask pixels per frame; snapshot them at frame end and clear them to the inverted extremes; latch them at UPDATE.
  - Stage 2 draws a 1-pixel green (00,FF,00) rectangle on the bounding-box edges under the same overlay_en/cent_valid gating.
  - The crosshair has priority where the two overlap.
- When not defined: no bounding-box registers or logic, and behaviour is exactly as above.

Test Plan:
- Reset: hold reset_n=0 for 4 cycles with random inputs → all outputs 0 and cent_valid=0. Release → video is echoed 2 cycles later.
- Block: 8x8 mask at x 100..107, y 50..57 in a 1280x720 frame, then vs rise → within 67 cycles cx=103, cy=53 (floored), cent_valid=1, led=3'b111.
  - Next frame: red at (103, 37..69) and (87..119, 53); all other pixels unchanged.
- Empty frame (cnt=0), then a frame with 63 pixels → cent_valid=0 after each CHECK, no overlay, FSM back in IDLE within 2 cycles.
- overlay_en=0 with a valid centroid → RGB out is bit-exact with the input delayed 2 cycles; cx and cy still update each frame.
- Second vs rise 10 cycles into DIV_X, with the new frame a block centred at (600,400) → the old cx/cy hold until UPDATE, then 600/400 with no intermediate value.
- reset_n=0 for 1 cycle during DIV_Y → cent_valid=0 and FSM in IDLE. The next full frame yields the correct centroid.
